desloc_ctrl: RTL and testbench
==============================

Name: desloc_ctrl

Overview:
- Command sequencer for the 4-bit shift register (op 00 NOP, 01 SHL, 10 SHR, 11 LOAD).
- Accepts one command at a time over a valid/ready handshake.
- Drives the register's op, parallel and serial inputs for the required number of cycles, then pulses done.
- Sits between the control logic and the shift register; also provides rotate-left by feeding the register MSB back into serial_in.

Parameters:
- WIDTH, 4, width of the controlled register and of cmd_data / reg_q / reg_parallel.
- CNT_W, 3, width of cmd_count; maximum shift count is 2^CNT_W-1 (7).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_kind  input  2  00 LOAD, 01 SHL, 10 SHR, 11 ROTL.
- cmd_count  input  CNT_W  number of shift/rotate steps; ignored for LOAD.
- cmd_data  input  WIDTH  parallel word for LOAD.
- cmd_fill  input  1  serial fill bit for SHL/SHR.
- reg_q  input  WIDTH  current register contents (register out port).
- reg_op  output  2  op to the register.
- reg_parallel  output  WIDTH  to register parallel_in.
- reg_serial  output  1  to register serial_in.
- busy  output  1  command in progress (state != IDLE).
- done  output  1  one-cycle pulse; register holds the final result during this cycle.

Behaviour:
- Reset (async): state IDLE, internal kind/count/data/fill latches 0, reg_op=00, reg_parallel=0, reg_serial=0, busy=0, done=0, cmd_ready=1 once reset deasserts.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1, reg_op=00.
  - On cmd_valid&&cmd_ready, latch kind/count/data/fill.
  - Next state: LOAD if kind=00; DONE if count=0; else SHIFT.
- LOAD: exactly one cycle, reg_op=11, reg_parallel=latched data; next state DONE.
- SHIFT:
  - reg_op=01 for SHL/ROTL, 10 for SHR.
  - reg_serial = latched fill for SHL/SHR; combinationally reg_q[WIDTH-1] for ROTL.
  - Remaining counter loaded with count on accept and decremented each SHIFT cycle; leaves SHIFT to DONE after exactly count cycles.
- DONE: exactly one cycle, done=1, reg_op=00, busy=1; next state IDLE.
- Latency from accept edge:
  - LOAD: done in cycle 2, ready in cycle 3.
  - Shift of n>0: done in cycle n+1, ready in cycle n+2.
  - n=0: done in cycle 1, register untouched.
- reg_parallel always shows the latched data (holds between commands); reg_serial shows latched fill outside ROTL SHIFT cycles.
- cmd_valid while busy is ignored (not accepted, not queued); the requester must hold cmd_valid until the handshake.
- reg_op is never 11 outside LOAD and never 01/10 outside SHIFT.
- Reset mid-command: immediate return to IDLE, outputs to reset values, command discarded, no done pulse.
- Count arithmetic unsigned CNT_W bits; no wrap (decrement stops at exit).

Optional Feature:
- Macro DESLOC_CTRL_ABORT_EN.
- Defined: adds input abort (1) and output aborted (1).
  - abort high during a SHIFT cycle forces reg_op=00 that cycle and moves to DONE; done=1 and aborted=1 together in that DONE cycle.
  - abort is ignored in IDLE/LOAD/DONE; aborted resets to 0.
- Not defined: no abort/aborted ports; every accepted command runs to completion.

Test Plan:
- Reset, then LOAD cmd_data=4'b1011 → reg_op=11 for one cycle, done pulse next cycle, register=1011, cmd_ready back high one cycle after done.
- From 1011: SHL count=2 fill=0 → two cycles reg_op=01, register 0110 then 1100, done after the 2nd shift.
- From 1100: SHR count=3 fill=1 → register 1110, 1111, 1111; done one cycle after the 3rd shift.
- LOAD 1001, then ROTL count=1 → reg_serial=1, register 0011. ROTL count=4 from 0011 → register returns to 0011.
- SHL count=0 → done the cycle after accept, reg_op stays 00. cmd_valid held during busy → only one accept, then second accepted when ready.
- Assert reset in the 2nd cycle of SHR count=5 → reg_op=00, busy=0, no done. With DESLOC_CTRL_ABORT_EN, abort in the 2nd SHIFT cycle → exactly one shift applied, done=aborted=1.

Source files
------------

// File: rtl/desloc_ctrl.sv
// desloc_ctrl: command sequencer for a 4-bit shift register.
//
// Commands are accepted one at a time over a valid/ready handshake:
//   LOAD (00), SHL (01), SHR (10) and ROTL (11).
// The controller then drives the register's op, parallel and serial inputs
// for the required number of cycles, and pulses done for one cycle while
// the register holds the final result.
//
// Ports:
//   clk, reset      - clock (rising edge), asynchronous active-high reset
//   cmd_valid/ready - command handshake; ready only while idle
//   cmd_kind        - 00 LOAD, 01 SHL, 10 SHR, 11 ROTL
//   cmd_count       - number of shift/rotate steps (ignored for LOAD)
//   cmd_data        - parallel word for LOAD
//   cmd_fill        - serial fill bit for SHL/SHR
//   reg_q           - current register contents
//   reg_op          - register op: 00 NOP, 01 SHL, 10 SHR, 11 LOAD
//   reg_parallel    - register parallel input (latched command data)
//   reg_serial      - register serial input
//   busy            - command in progress
//   done            - one-cycle completion pulse
//
// Optional feature (macro DESLOC_CTRL_ABORT_EN):
//   abort           - input; ends a shift/rotate early, suppressing the shift
//                     in the cycle it is seen
//   aborted         - output; high together with done after an abort
module desloc_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_kind,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] reg_q,
    output logic [1:0]       reg_op,
    output logic [WIDTH-1:0] reg_parallel,
    output logic             reg_serial,
    output logic             busy,
    output logic             done
`ifdef DESLOC_CTRL_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [1:0] KIND_LOAD = 2'b00;
    localparam logic [1:0] KIND_SHR  = 2'b10;
    localparam logic [1:0] KIND_ROTL = 2'b11;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b01;
    localparam logic [1:0] OP_SHR  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    state_t           state_q, state_d;
    logic [1:0]       kind_q, kind_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             fill_q, fill_d;
    logic [1:0]       reg_op_q, reg_op_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
`ifdef DESLOC_CTRL_ABORT_EN
    logic             aborted_q, aborted_d;
`endif

    // Only the MSB of the register is needed (rotate feedback).
    logic unused_reg_bits;
    assign unused_reg_bits = ^reg_q[WIDTH-2:0];

    // Next-state logic. Outputs are computed from the next state so that
    // they are registered and line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fill_d  = fill_q;
`ifdef DESLOC_CTRL_ABORT_EN
        aborted_d = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    kind_d = cmd_kind;
                    cnt_d  = cmd_count;
                    data_d = cmd_data;
                    fill_d = cmd_fill;
                    if (cmd_kind == KIND_LOAD) begin
                        state_d = S_LOAD;
                    end else if (cmd_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_DONE;
            end
            S_SHIFT: begin
                // The counter is never zero here, so the decrement cannot wrap.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
`ifdef DESLOC_CTRL_ABORT_EN
                if (abort) begin
                    state_d   = S_DONE;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        reg_op_d = OP_NOP;
        if (state_d == S_LOAD) begin
            reg_op_d = OP_LOAD;
        end else if (state_d == S_SHIFT) begin
            reg_op_d = (kind_d == KIND_SHR) ? OP_SHR : OP_SHL;
        end
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            kind_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            fill_q    <= 1'b0;
            reg_op_q  <= OP_NOP;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef DESLOC_CTRL_ABORT_EN
            aborted_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            fill_q    <= fill_d;
            reg_op_q  <= reg_op_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
`ifdef DESLOC_CTRL_ABORT_EN
            aborted_q <= aborted_d;
`endif
        end
    end

    assign cmd_ready    = ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign reg_parallel = data_q;

    // Rotate feeds the live MSB back in; everything else uses the latched fill.
    assign reg_serial = (state_q == S_SHIFT && kind_q == KIND_ROTL) ? reg_q[WIDTH-1] : fill_q;

`ifdef DESLOC_CTRL_ABORT_EN
    // An abort suppresses the shift in the very cycle it is seen.
    assign reg_op  = (state_q == S_SHIFT && abort) ? OP_NOP : reg_op_q;
    assign aborted = aborted_q;
`else
    assign reg_op = reg_op_q;
`endif

endmodule

// File: tb/tb_desloc_ctrl.sv
// tb_desloc_ctrl: self-checking bench for desloc_ctrl.
// Contains a behavioural 4-bit shift register as the controlled device and a
// reference model that computes each command's final register value with
// plain arithmetic. Build with DESLOC_CTRL_ABORT_EN to also exercise abort.
module tb_desloc_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_kind;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic [WIDTH-1:0] shreg = '0;
    logic [1:0]       reg_op;
    logic [WIDTH-1:0] reg_parallel;
    logic             reg_serial;
    logic             busy;
    logic             done;
    logic             abort = 1'b0;
    logic             aborted;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    desloc_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_kind     (cmd_kind),
        .cmd_count    (cmd_count),
        .cmd_data     (cmd_data),
        .cmd_fill     (cmd_fill),
        .reg_q        (shreg),
        .reg_op       (reg_op),
        .reg_parallel (reg_parallel),
        .reg_serial   (reg_serial),
        .busy         (busy),
        .done         (done)
`ifdef DESLOC_CTRL_ABORT_EN
        ,
        .abort        (abort),
        .aborted      (aborted)
`endif
    );

`ifndef DESLOC_CTRL_ABORT_EN
    assign aborted = 1'b0;
`endif

    // The controlled shift register.
    always @(posedge clk) begin
        case (reg_op)
            2'b01:   shreg <= {shreg[WIDTH-2:0], reg_serial};
            2'b10:   shreg <= {reg_serial, shreg[WIDTH-1:1]};
            2'b11:   shreg <= reg_parallel;
            default: ;
        endcase
    end

    // Final register value of a command, computed arithmetically.
    function automatic logic [3:0] ref_result(input int kind, input int n, input int data,
                                              input int fill, input int cur);
        int v;
        v = cur;
        if (kind == 0) return data[3:0];
        for (int i = 0; i < n; i++) begin
            case (kind)
                1: v = (v * 2 + fill) % 16;
                2: v = v / 2 + fill * 8;
                default: v = (v * 2) % 16 + v / 8;
            endcase
        end
        return v[3:0];
    endfunction

    // Issues one command and follows it to its done cycle, reporting the
    // latency, the number of active-op cycles and idle-busy cycles observed.
    task automatic do_cmd(input int kind, input int n, input int data, input int fill,
                          output int lat, output int ops, output int not_busy, output bit to);
        int g;
        to = 0; lat = 0; ops = 0; not_busy = 0;
        @(negedge clk);
        cmd_kind  = kind[1:0];
        cmd_count = n[CNT_W-1:0];
        cmd_data  = data[WIDTH-1:0];
        cmd_fill  = fill[0];
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            to = 1;
            cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            if (reg_op !== 2'b00) ops++;
            if (busy !== 1'b1) not_busy++;
            @(negedge clk);
            lat++;
        end
        if (!done) to = 1;
        if (busy !== 1'b1) not_busy++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd_valid = 1'b0; cmd_kind = '0; cmd_count = '0; cmd_data = '0; cmd_fill = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
        checks++; if (reg_op !== 2'b00) $display("[TB] FAIL reset_op: got %b expected 00", reg_op); else passed++;
        checks++; if (reg_parallel !== 4'b0000) $display("[TB] FAIL reset_par: got %b expected 0000", reg_parallel); else passed++;
        checks++; if (reg_serial !== 1'b0) $display("[TB] FAIL reset_ser: got %b expected 0", reg_serial); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); else passed++;
    endtask

    task automatic test_directed();
        int k_tab[7] = '{0, 1, 2, 0, 3, 3, 1};
        int n_tab[7] = '{0, 2, 3, 0, 1, 4, 0};
        int d_tab[7] = '{4'b1011, 0, 0, 4'b1001, 0, 0, 0};
        int f_tab[7] = '{0, 0, 1, 0, 0, 0, 1};
        int e_tab[7] = '{4'b1011, 4'b1100, 4'b1111, 4'b1001, 4'b0011, 4'b0011, 4'b0011};
        int lat, ops, nb, exp_lat, exp_ops;
        bit to;
        for (int i = 0; i < 7; i++) begin
            do_cmd(k_tab[i], n_tab[i], d_tab[i], f_tab[i], lat, ops, nb, to);
            exp_lat = (k_tab[i] == 0) ? 2 : n_tab[i] + 1;
            exp_ops = (k_tab[i] == 0) ? 1 : n_tab[i];
            checks++; if (to) $display("[TB] FAIL dir_timeout[%0d]: got timeout expected done", i); else passed++;
            checks++; if (lat != exp_lat) $display("[TB] FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); else passed++;
            checks++; if (ops != exp_ops) $display("[TB] FAIL dir_opcycles[%0d]: got %0d expected %0d", i, ops, exp_ops); else passed++;
            checks++; if (nb != 0) $display("[TB] FAIL dir_busy[%0d]: got %0d idle cycles expected 0", i, nb); else passed++;
            checks++; if (shreg !== e_tab[i][3:0]) $display("[TB] FAIL dir_result[%0d]: got %b expected %b", i, shreg, e_tab[i][3:0]); else passed++;
            checks++; if (reg_op !== 2'b00) $display("[TB] FAIL dir_done_op[%0d]: got %b expected 00", i, reg_op); else passed++;
            @(negedge clk);
            checks++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("[TB] FAIL dir_ready[%0d]: got ready=%b done=%b expected ready=1 done=0", i, cmd_ready, done); else passed++;
        end
    endtask

    task automatic test_random();
        int kind, n, data, fill, lat, ops, nb, exp_lat, exp_ops;
        logic [3:0] model_val;
        bit to;
        model_val = 4'b0000;
        for (int i = 0; i < 24; i++) begin
            kind = (i == 0) ? 0 : int'($urandom_range(0, 3));
            n    = int'($urandom_range(0, 7));
            data = int'($urandom_range(0, 15));
            fill = int'($urandom_range(0, 1));
            model_val = ref_result(kind, n, data, fill, int'(model_val));
            exp_lat = (kind == 0) ? 2 : n + 1;
            exp_ops = (kind == 0) ? 1 : n;
            do_cmd(kind, n, data, fill, lat, ops, nb, to);
            checks++; if (to || lat != exp_lat) $display("[TB] FAIL rnd_latency[%0d]: got %0d (timeout=%0d) expected %0d", i, lat, to, exp_lat); else passed++;
            checks++; if (ops != exp_ops || nb != 0) $display("[TB] FAIL rnd_ops[%0d]: got ops=%0d idle=%0d expected ops=%0d idle=0", i, ops, nb, exp_ops); else passed++;
            checks++; if (shreg !== model_val) $display("[TB] FAIL rnd_result[%0d]: got %b expected %b (kind %0d n %0d)", i, shreg, model_val, kind, n); else passed++;
            @(negedge clk);
            checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rnd_ready[%0d]: got %b expected 1", i, cmd_ready); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int lat, ops, nb, acc;
        bit to;
        logic [3:0] exp_val;
        do_cmd(0, 0, 4'b0001, 0, lat, ops, nb, to);
        @(negedge clk);
        cmd_kind = 2'b11; cmd_count = 3'd3; cmd_fill = 1'b0; cmd_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            if (cmd_ready) acc++;
            @(negedge clk);
        end
        checks++; if (acc != 1) $display("[TB] FAIL b2b_accepts: got %0d expected 1", acc); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL b2b_second_ready: got %b expected 1", cmd_ready); else passed++;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        exp_val = ref_result(3, 3, 0, 0, int'(ref_result(3, 3, 0, 0, 1)));
        checks++; if (lat != 4) $display("[TB] FAIL b2b_latency: got %0d expected 4", lat); else passed++;
        checks++; if (shreg !== exp_val) $display("[TB] FAIL b2b_result: got %b expected %b", shreg, exp_val); else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, ops, nb, dones;
        bit to;
        do_cmd(0, 0, 4'b1111, 0, lat, ops, nb, to);
        @(negedge clk);
        cmd_kind = 2'b10; cmd_count = 3'd5; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (reg_op !== 2'b00) $display("[TB] FAIL rstmid_op: got %b expected 00", reg_op); else passed++;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else passed++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL rstmid_done: got %b expected 0", done); else passed++;
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dones++;
            @(negedge clk);
        end
        checks++; if (dones != 0) $display("[TB] FAIL rstmid_nodone: got %0d pulses expected 0", dones); else passed++;
        checks++; if (shreg !== ref_result(2, 1, 0, 0, 4'b1111)) $display("[TB] FAIL rstmid_shifts: got %b expected %b", shreg, ref_result(2, 1, 0, 0, 4'b1111)); else passed++;
        checks++; if (cmd_ready !== 1'b1) $display("[TB] FAIL rstmid_ready: got %b expected 1", cmd_ready); else passed++;
    endtask

`ifdef DESLOC_CTRL_ABORT_EN
    task automatic test_abort();
        int lat, ops, nb;
        bit to;
        do_cmd(0, 0, 4'b0101, 0, lat, ops, nb, to);
        @(negedge clk);
        cmd_kind = 2'b01; cmd_count = 3'd4; cmd_fill = 1'b0; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        #1;
        checks++; if (reg_op !== 2'b00) $display("[TB] FAIL abort_op: got %b expected 00", reg_op); else passed++;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (done !== 1'b1 || aborted !== 1'b1) $display("[TB] FAIL abort_flags: got done=%b aborted=%b expected 1 1", done, aborted); else passed++;
        checks++; if (shreg !== ref_result(1, 1, 0, 0, 4'b0101)) $display("[TB] FAIL abort_result: got %b expected %b", shreg, ref_result(1, 1, 0, 0, 4'b0101)); else passed++;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || aborted !== 1'b0) $display("[TB] FAIL abort_after: got ready=%b aborted=%b expected 1 0", cmd_ready, aborted); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef DESLOC_CTRL_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
